lsd_frame_buffer: RTL and testbench
===================================

LSD_FRAME_BUFFER -- requirements
Module: lsd_frame_buffer

Interface
REQ-001 The block SHALL have one clock, `clock`, and a synchronous active-high reset, `rst`; all state SHALL update on the rising edge of `clock`.
REQ-002 Parameters (name, default, meaning) SHALL be:
- FRAME_HEIGHT, 480, vertical coordinate range.
- FRAME_WIDTH, 640, horizontal coordinate range.
- RAM_SIZE, 4096, segments per bank.
- MIN_LENGTH, 0, minimum segment length; 0 disables the filter.
REQ-003 Derived widths SHALL be: V_BITW=log2ceil(FRAME_HEIGHT), H_BITW=log2ceil(FRAME_WIDTH), ADDR_BITW=log2ceil(RAM_SIZE), WORD_SIZE=2*(V_BITW+H_BITW).
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clock, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_flag, in, 1, high while the detector streams one frame.
- in_valid, in, 1, the segment on the coordinate inputs is valid this cycle.
- in_start_v / in_end_v, in, V_BITW, segment vertical endpoints.
- in_start_h / in_end_h, in, H_BITW, segment horizontal endpoints.
- in_rd_addr, in, ADDR_BITW, PS read address.
- in_release, in, 1, one-cycle pulse: PS finished with the presented frame.
- out_ready, out, 1, a committed frame is presented.
- out_line_num, out, ADDR_BITW+1, segment count of the presented frame.
- out_overflow, out, 1, the presented frame was truncated.
- out_data, out, WORD_SIZE, {start_v,start_h,end_v,end_h} at the registered address.
- out_start_v / out_start_h / out_end_v / out_end_h, out, field widths, unpacked out_data.
- out_frame_cnt, out, 16, frames presented, wrapping.
- out_drop_cnt, out, 8, completed frames discarded unread, saturating at 255.

Function
REQ-005 Storage SHALL be two banks of RAM_SIZE x WORD_SIZE; rd_bank is the presented bank and the write bank SHALL always be ~rd_bank.
REQ-006 Frame start SHALL be detected as in_flag rising (0->1) and frame end as in_flag falling (1->0), using a registered copy of in_flag.
REQ-007 At frame start, wr_addr SHALL be set to 0, the overflow latch cleared, and any pending frame discarded (pend_valid<=0, out_drop_cnt+1).
REQ-008 A segment SHALL be accepted when in_flag && in_valid && length>=MIN_LENGTH, where length=|end_v-start_v|+|end_h-start_h|.
- The length SHALL be computed unsigned in max(V_BITW,H_BITW)+2 bits with no truncation.
REQ-009 An accepted segment SHALL be written to write bank[wr_addr] and wr_addr incremented; accepted segments with wr_addr==RAM_SIZE SHALL be ignored and SHALL set the overflow latch.
- The count SHALL saturate at RAM_SIZE.
REQ-010 At frame end with count 0, the SHALL commit nothing and leave all outputs unchanged.
REQ-011 At frame end with count>0, the frame SHALL be committed as follows:
- If out_ready is 0: rd_bank<=write bank, out_ready<=1, out_line_num<=count, out_overflow<=latch, out_frame_cnt+1, all visible the next cycle.
- Otherwise: pend_valid<=1, and count and latch SHALL be stored as pending.
REQ-012 On in_release with out_ready=1:
- If pend_valid: rd_bank SHALL flip, the pending count and overflow SHALL be presented, pend_valid<=0, out_frame_cnt+1, and out_ready SHALL stay 1.
- Otherwise: out_ready<=0.
- in_release with out_ready=0 SHALL be ignored.
REQ-013 When in_release and a frame-end commit occur in the same cycle, release SHALL be evaluated first, so the new frame is presented directly (out_ready stays 1, no pending entry).
REQ-014 pend_valid SHALL never be 1 while a frame is being written.
REQ-015 out_data SHALL have one-cycle registered read latency from in_rd_addr and SHALL read rd_bank as of the address-sample cycle; it is undefined while out_ready=0.
REQ-016 The presented bank SHALL never be written while out_ready=1.

Reset
REQ-017 On rst, all of the following SHALL be 0: out_ready, out_line_num, out_overflow, out_frame_cnt, out_drop_cnt, pend_valid, wr_addr, rd_bank.
- The registered in_flag copy SHALL reset to 1, so a frame in progress at reset release is ignored until in_flag falls.
- RAM contents SHALL NOT be reset.
REQ-018 Reset asserted mid-frame or mid-read SHALL discard all frames with no further commits.

Verification
REQ-019 Basic: RAM_SIZE=16; frame of 5 valid segments, then in_flag falls -> next cycle out_ready=1, out_line_num=5, out_frame_cnt=1; reading addresses 0..4 returns the written words one cycle later.
REQ-020 Overflow: 20 segments into RAM_SIZE=16 -> out_line_num=16, out_overflow=1; addresses 0..15 hold the first 16 segments.
REQ-021 Pending/drop: frame A presented; frames B and C complete without release -> out_drop_cnt=1; release -> C presented, out_frame_cnt=2; release -> out_ready=0.
REQ-022 Filter: MIN_LENGTH=10; segments of length 9, 10 and 25 -> out_line_num=2; a frame with only short segments -> no commit.
REQ-023 Simultaneous: release in the same cycle as frame end of frame B while A is presented -> B presented next cycle, out_ready stays 1, pend_valid=0.
REQ-024 Reset: rst asserted mid-frame and released with in_flag=1 -> no commit until the next full frame; all outputs 0.

Source files
------------

// File: rtl/lsd_frame_buffer.sv
// Double-buffered line-segment frame store between the segment detector and the PS reader.
// One bank fills while the other is presented; a single finished frame may wait for the reader.
module lsd_frame_buffer #(
    parameter int FRAME_HEIGHT = 480,
    parameter int FRAME_WIDTH  = 640,
    parameter int RAM_SIZE     = 4096,
    parameter int MIN_LENGTH   = 0,
    localparam int V_BITW      = $clog2(FRAME_HEIGHT),
    localparam int H_BITW      = $clog2(FRAME_WIDTH),
    localparam int ADDR_BITW   = $clog2(RAM_SIZE),
    localparam int WORD_SIZE   = 2 * (V_BITW + H_BITW)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   in_flag,
    input  logic                   in_valid,
    input  logic [V_BITW-1:0]      in_start_v,
    input  logic [H_BITW-1:0]      in_start_h,
    input  logic [V_BITW-1:0]      in_end_v,
    input  logic [H_BITW-1:0]      in_end_h,
    input  logic [ADDR_BITW-1:0]   in_rd_addr,
    input  logic                   in_release,
    output logic                   out_ready,
    output logic [ADDR_BITW:0]     out_line_num,
    output logic                   out_overflow,
    output logic [WORD_SIZE-1:0]   out_data,
    output logic [V_BITW-1:0]      out_start_v,
    output logic [H_BITW-1:0]      out_start_h,
    output logic [V_BITW-1:0]      out_end_v,
    output logic [H_BITW-1:0]      out_end_h,
    output logic [15:0]            out_frame_cnt,
    output logic [7:0]             out_drop_cnt
);

    localparam int LEN_W = ((V_BITW > H_BITW) ? V_BITW : H_BITW) + 2;
    localparam logic [ADDR_BITW:0] FULL = (ADDR_BITW + 1)'(RAM_SIZE);
    localparam logic [ADDR_BITW:0] ONE  = (ADDR_BITW + 1)'(1);

    logic                 flag_q, flag_d;
    logic                 act_q, act_d;
    logic [ADDR_BITW:0]   wr_addr_q, wr_addr_d;
    logic                 ovf_latch_q, ovf_latch_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 out_ready_q, out_ready_d;
    logic [ADDR_BITW:0]   line_num_q, line_num_d;
    logic                 out_ovf_q, out_ovf_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [ADDR_BITW:0]   pend_cnt_q, pend_cnt_d;
    logic                 pend_ovf_q, pend_ovf_d;
    logic [WORD_SIZE-1:0] rd_data_q;

    logic [WORD_SIZE-1:0] mem [2][RAM_SIZE];

    logic                 frame_start, frame_end;
    logic [LEN_W-1:0]     sv, ev, sh, eh, dv, dh, seg_len;
    logic                 len_ok, accept, wr_en;
    logic [ADDR_BITW:0]   wr_ptr;
    logic                 latch_in;
    logic [WORD_SIZE-1:0] wr_word;

    // Widened before subtracting so the Manhattan length never truncates.
    always_comb begin
        sv      = LEN_W'(in_start_v);
        ev      = LEN_W'(in_end_v);
        sh      = LEN_W'(in_start_h);
        eh      = LEN_W'(in_end_h);
        dv      = (ev >= sv) ? ev - sv : sv - ev;
        dh      = (eh >= sh) ? eh - sh : sh - eh;
        seg_len = dv + dh;
    end

    if (MIN_LENGTH == 0) begin : g_nofilt
        assign len_ok = 1'b1;
    end else begin : g_filt
        localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_LENGTH);
        assign len_ok = (seg_len >= MIN_LEN);
    end

    assign frame_start = in_flag && !flag_q;
    assign frame_end   = !in_flag && flag_q;
    assign wr_ptr      = frame_start ? '0 : wr_addr_q;
    assign latch_in    = frame_start ? 1'b0 : ovf_latch_q;
    // A frame already running when reset drops is never active, so it cannot commit.
    assign accept      = in_flag && in_valid && len_ok && (act_q || frame_start);
    assign wr_en       = accept && (wr_ptr != FULL);
    assign wr_word     = {in_start_v, in_start_h, in_end_v, in_end_h};

    always_comb begin
        flag_d       = in_flag;
        act_d        = act_q;
        wr_addr_d    = wr_addr_q;
        ovf_latch_d  = ovf_latch_q;
        rd_bank_d    = rd_bank_q;
        out_ready_d  = out_ready_q;
        line_num_d   = line_num_q;
        out_ovf_d    = out_ovf_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_cnt_d   = pend_cnt_q;
        pend_ovf_d   = pend_ovf_q;

        if (in_release && out_ready_q) begin
            if (pend_valid_q) begin
                rd_bank_d    = ~rd_bank_q;
                line_num_d   = pend_cnt_q;
                out_ovf_d    = pend_ovf_q;
                pend_valid_d = 1'b0;
                frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
                out_ready_d = 1'b0;
            end
        end

        if (frame_start) begin
            act_d       = 1'b1;
            wr_addr_d   = '0;
            ovf_latch_d = 1'b0;
            if (pend_valid_d) begin
                pend_valid_d = 1'b0;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        if (accept) begin
            if (wr_ptr == FULL) ovf_latch_d = 1'b1;
            else                wr_addr_d   = wr_ptr + ONE;
        end

        // Release was resolved above, so a same-cycle release lets this frame present directly.
        if (frame_end && act_q) begin
            act_d = 1'b0;
            if (wr_addr_q != '0) begin
                if (!out_ready_d) begin
                    rd_bank_d   = ~rd_bank_q;
                    out_ready_d = 1'b1;
                    line_num_d  = wr_addr_q;
                    out_ovf_d   = latch_in;
                    frame_cnt_d = frame_cnt_d + 16'd1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_cnt_d   = wr_addr_q;
                    pend_ovf_d   = latch_in;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            flag_q       <= 1'b1;
            act_q        <= 1'b0;
            wr_addr_q    <= '0;
            ovf_latch_q  <= 1'b0;
            rd_bank_q    <= 1'b0;
            out_ready_q  <= 1'b0;
            line_num_q   <= '0;
            out_ovf_q    <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_cnt_q   <= '0;
            pend_ovf_q   <= 1'b0;
        end else begin
            flag_q       <= flag_d;
            act_q        <= act_d;
            wr_addr_q    <= wr_addr_d;
            ovf_latch_q  <= ovf_latch_d;
            rd_bank_q    <= rd_bank_d;
            out_ready_q  <= out_ready_d;
            line_num_q   <= line_num_d;
            out_ovf_q    <= out_ovf_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_ovf_q   <= pend_ovf_d;
        end
    end

    // Writes only ever target the bank that is not presented.
    always_ff @(posedge clock) begin
        if (wr_en && !rst) mem[~rd_bank_q][wr_ptr[ADDR_BITW-1:0]] <= wr_word;
        rd_data_q <= mem[rd_bank_q][in_rd_addr];
    end

    assign out_ready     = out_ready_q;
    assign out_line_num  = line_num_q;
    assign out_overflow  = out_ovf_q;
    assign out_frame_cnt = frame_cnt_q;
    assign out_drop_cnt  = drop_cnt_q;
    assign out_data      = rd_data_q;
    assign out_start_v   = rd_data_q[WORD_SIZE-1 -: V_BITW];
    assign out_start_h   = rd_data_q[2*H_BITW+V_BITW-1 -: H_BITW];
    assign out_end_v     = rd_data_q[H_BITW+V_BITW-1 -: V_BITW];
    assign out_end_h     = rd_data_q[H_BITW-1:0];

endmodule

// File: tb/tb_lsd_frame_buffer.sv
// Directed bench for lsd_frame_buffer: small RAM, length filter of 10, read-back via a scoreboard queue.
module tb_lsd_frame_buffer;

    localparam int RAM = 16;
    localparam int MINL = 10;

    logic        clock, rst, in_flag, in_valid, in_release;
    logic [8:0]  in_start_v, in_end_v;
    logic [9:0]  in_start_h, in_end_h;
    logic [3:0]  in_rd_addr;
    logic        out_ready, out_overflow;
    logic [4:0]  out_line_num;
    logic [37:0] out_data;
    logic [8:0]  out_start_v, out_end_v;
    logic [9:0]  out_start_h, out_end_h;
    logic [15:0] out_frame_cnt;
    logic [7:0]  out_drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [37:0] last_frame[$];
    logic [37:0] pres_words[$];
    logic [37:0] exp_q[$];
    logic [37:0] w;

    lsd_frame_buffer #(.FRAME_HEIGHT(480), .FRAME_WIDTH(640), .RAM_SIZE(RAM), .MIN_LENGTH(MINL)) dut (
        .clock(clock), .rst(rst), .in_flag(in_flag), .in_valid(in_valid),
        .in_start_v(in_start_v), .in_start_h(in_start_h), .in_end_v(in_end_v), .in_end_h(in_end_h),
        .in_rd_addr(in_rd_addr), .in_release(in_release),
        .out_ready(out_ready), .out_line_num(out_line_num), .out_overflow(out_overflow),
        .out_data(out_data), .out_start_v(out_start_v), .out_start_h(out_start_h),
        .out_end_v(out_end_v), .out_end_h(out_end_h),
        .out_frame_cnt(out_frame_cnt), .out_drop_cnt(out_drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_frame();
        in_flag = 1'b1;
        last_frame.delete();
        tick();
    endtask

    task automatic seg(input int sv, input int sh, input int ev, input int eh);
        int dv, dh;
        dv = (ev >= sv) ? ev - sv : sv - ev;
        dh = (eh >= sh) ? eh - sh : sh - eh;
        in_valid = 1'b1;
        in_start_v = 9'(sv); in_start_h = 10'(sh);
        in_end_v = 9'(ev);   in_end_h = 10'(eh);
        if (dv + dh >= MINL && last_frame.size() < RAM)
            last_frame.push_back({9'(sv), 10'(sh), 9'(ev), 10'(eh)});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic end_frame(input bit rel);
        in_flag = 1'b0;
        in_release = rel;
        tick();
        in_release = 1'b0;
    endtask

    task automatic gen_frame(input int n, input int base);
        begin_frame();
        for (int i = 0; i < n; i++) begin
            int sv, sh;
            sv = (base + i * 7) % 400;
            sh = (base * 3 + i * 11) % 600;
            seg(sv, sh, sv + 4 + (i % 4), sh + 6);
        end
        end_frame(1'b0);
    endtask

    task automatic release_pulse();
        in_release = 1'b1;
        tick();
        in_release = 1'b0;
    endtask

    task automatic read_all(input int n);
        for (int i = 0; i < n; i++) begin
            in_rd_addr = 4'(i);
            exp_q.push_back(pres_words[i]);
            tick();
            chk($sformatf("rd_data[%0d]", i), 64'(out_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic chk_state(input string tag, input logic rdy, input int line, input logic ovf,
                             input int fcnt, input int dcnt);
        chk({tag, ".ready"}, 64'(out_ready), 64'(rdy));
        chk({tag, ".line"}, 64'(out_line_num), 64'(line));
        chk({tag, ".ovf"}, 64'(out_overflow), 64'(ovf));
        chk({tag, ".fcnt"}, 64'(out_frame_cnt), 64'(fcnt));
        chk({tag, ".dcnt"}, 64'(out_drop_cnt), 64'(dcnt));
    endtask

    initial begin
        rst = 1'b1; in_flag = 1'b0; in_valid = 1'b0; in_release = 1'b0;
        in_start_v = '0; in_start_h = '0; in_end_v = '0; in_end_h = '0; in_rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_state("reset", 1'b0, 0, 1'b0, 0, 0);

        // basic frame of 5
        gen_frame(5, 20);
        chk_state("basic", 1'b1, 5, 1'b0, 1, 0);
        pres_words = last_frame;
        read_all(5);
        in_rd_addr = 4'd2;
        tick();
        w = pres_words[2];
        chk("start_v", 64'(out_start_v), 64'(w[37:29]));
        chk("start_h", 64'(out_start_h), 64'(w[28:19]));
        chk("end_v", 64'(out_end_v), 64'(w[18:10]));
        chk("end_h", 64'(out_end_h), 64'(w[9:0]));
        release_pulse();
        chk("basic.rel_ready", 64'(out_ready), 64'd0);

        // overflow: 20 into 16
        gen_frame(20, 55);
        chk_state("ovf", 1'b1, 16, 1'b1, 2, 0);
        pres_words = last_frame;
        read_all(16);
        release_pulse();

        // length filter: 9, 10, 25
        begin_frame();
        seg(100, 100, 104, 105);
        seg(100, 100, 105, 105);
        seg(200, 300, 190, 285);
        end_frame(1'b0);
        chk_state("filt", 1'b1, 2, 1'b0, 3, 0);
        pres_words = last_frame;
        read_all(2);
        release_pulse();
        begin_frame();
        seg(10, 10, 12, 13);
        seg(50, 50, 50, 59);
        end_frame(1'b0);
        tick();
        chk("short.ready", 64'(out_ready), 64'd0);
        chk("short.fcnt", 64'(out_frame_cnt), 64'd3);

        // pending and drop
        gen_frame(3, 70);
        chk_state("pendA", 1'b1, 3, 1'b0, 4, 0);
        gen_frame(2, 90);
        chk_state("pendB", 1'b1, 3, 1'b0, 4, 0);
        gen_frame(4, 110);
        chk_state("pendC", 1'b1, 3, 1'b0, 4, 1);
        release_pulse();
        chk_state("pendRel", 1'b1, 4, 1'b0, 5, 1);
        pres_words = last_frame;
        read_all(4);
        release_pulse();
        chk("pend.rel2_ready", 64'(out_ready), 64'd0);

        // release coincident with frame end
        gen_frame(2, 130);
        chk_state("simA", 1'b1, 2, 1'b0, 6, 1);
        begin_frame();
        for (int i = 0; i < 3; i++) seg(300 + i, 400, 310 + i, 402);
        end_frame(1'b1);
        chk_state("simB", 1'b1, 3, 1'b0, 7, 1);
        pres_words = last_frame;
        read_all(3);
        release_pulse();
        chk("sim.no_pend", 64'(out_ready), 64'd0);

        // reset mid-frame, released with in_flag high
        begin_frame();
        seg(10, 10, 30, 30);
        seg(20, 20, 40, 40);
        rst = 1'b1;
        tick();
        seg(30, 30, 50, 50);
        rst = 1'b0;
        seg(40, 40, 60, 60);
        seg(50, 50, 70, 70);
        end_frame(1'b0);
        tick();
        chk_state("rstmid", 1'b0, 0, 1'b0, 0, 0);
        gen_frame(2, 150);
        chk_state("rstnext", 1'b1, 2, 1'b0, 1, 0);
        pres_words = last_frame;
        read_all(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
